// File: rtl/sub_seq_257bit.sv
// sub_seq_257bit: sequential (W+1)-bit a-b, one SLICE per cycle LSB first, with eq/gt/lt from the borrow chain.
module sub_seq_257bit #(
   parameter int W     = 256,
   parameter int SLICE = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W:0]   a,
   input  logic [W:0]   b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   diff,
   output logic         eq,
   output logic         gt,
   output logic         lt
);
   localparam int N  = W / SLICE + 1;
   localparam int CW = $clog2(N);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;
   logic [W:0]    a_q, b_q;
   logic [W-1:0]  work;
   logic [CW-1:0] cnt;
   logic          borrow, nonzero, r1, bo1, last, nz_fin;
   logic [SLICE:0] s;
   always_comb begin
      s         = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]} - {{SLICE{1'b0}}, borrow};
      r1        = a_q[0] ^ b_q[0] ^ borrow;
      bo1       = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow);
      nz_fin    = nonzero | r1;
      last      = cnt == CW'(N - 1);
      in_ready  = state == IDLE;
      out_valid = state == DONE;
      state_nx  = state == IDLE ? (in_valid ? BUSY : IDLE) :
                  state == BUSY ? (last ? DONE : BUSY) :
                  (out_ready ? IDLE : DONE);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   // operands shift down so the current slice is always at bit 0; after N-1 shifts bit W sits at bit 0
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         work    <= '0;
         cnt     <= '0;
         borrow  <= 1'b0;
         nonzero <= 1'b0;
         diff    <= '0;
         eq      <= 1'b0;
         gt      <= 1'b0;
         lt      <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_q     <= a;
         b_q     <= b;
         cnt     <= '0;
         borrow  <= 1'b0;
         nonzero <= 1'b0;
      end else if (state == BUSY && !last) begin
         a_q     <= a_q >> SLICE;
         b_q     <= b_q >> SLICE;
         work    <= {s[SLICE-1:0], work[W-1:SLICE]};
         borrow  <= s[SLICE];
         nonzero <= nonzero | (|s[SLICE-1:0]);
         cnt     <= cnt + 1'b1;
      end else if (state == BUSY) begin
         borrow  <= bo1;
         nonzero <= nz_fin;
         diff    <= {r1, work};
         lt      <= bo1;
         eq      <= !nz_fin & !bo1;
         gt      <= nz_fin & !bo1;
      end
endmodule

// File: tb/tb_sub_seq_257bit.sv
// tb_sub_seq_257bit: directed table, handshake/reset corner sequences and random pairs against a scoreboard.
module tb_sub_seq_257bit;
   localparam int W = 256;
   typedef struct {
      logic [W:0] a, b, d;
      logic       eq, gt, lt;
   } vec_t;
   logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [W:0] a = '0, b = '0;
   logic       in_ready, out_valid, eq, gt, lt;
   logic [W:0] diff;
   int         n_chk = 0, n_fail = 0;
   vec_t       q[$];
   vec_t       tbl[6];

   sub_seq_257bit #(.W(W), .SLICE(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .eq(eq), .gt(gt), .lt(lt)
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [W:0] got, input logic [W:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   always @(negedge clk)
      if (!rst && out_valid && out_ready) begin
         vec_t e;
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result: got diff %h with empty scoreboard", diff);
         end else begin
            e = q.pop_front();
            chk("diff", diff, e.d);
            chk("eq", eq, e.eq);
            chk("gt", gt, e.gt);
            chk("lt", lt, e.lt);
         end
      end

   function automatic logic [W:0] rnd();
      logic [287:0] r;
      for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
      return r[W:0];
   endfunction

   function automatic vec_t model(input logic [W:0] av, input logic [W:0] bv);
      vec_t e;
      e.a  = av;
      e.b  = bv;
      e.d  = av - bv;
      e.eq = av == bv;
      e.gt = av > bv;
      e.lt = av < bv;
      return e;
   endfunction

   task automatic start_op(input vec_t e);
      int t = 0;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1; t++;
      end
      chk("accept_ready", in_ready, 1);
      a = e.a;
      b = e.b;
      in_valid = 1'b1;
      @(posedge clk);
      q.push_back(e);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(input int lat);
      int t = 0;
      while (!out_valid && t < 30) begin
         @(posedge clk); #1; t++;
      end
      chk("latency", t, lat);
   endtask

   task automatic run(input vec_t e);
      start_op(e);
      wait_out(9);
      @(posedge clk); #1;
      chk("in_ready_after_hs", {in_ready, out_valid}, 2'b10);
   endtask

   initial begin
      vec_t e;
      tbl[0] = '{{1'b1, {W{1'b1}}}, {1'b1, {W{1'b1}}}, {(W+1){1'b0}}, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{{1'b1, {W{1'b0}}}, (W+1)'(1), {1'b0, {W{1'b1}}}, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{{(W+1){1'b0}}, (W+1)'(1), {(W+1){1'b1}}, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{{1'b1, {W{1'b0}}}, {(W+1){1'b0}}, {1'b1, {W{1'b0}}}, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{(W+1)'(3), (W+1)'(5), {{W{1'b1}}, 1'b0}, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{(W+1)'(5), (W+1)'(3), (W+1)'(2), 1'b0, 1'b1, 1'b0};
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hs", {in_ready, out_valid}, 2'b10);
      chk("reset_diff", diff, '0);
      chk("reset_flags", {eq, gt, lt}, 3'b000);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) run(tbl[i]);
      // back-pressure: operands scrambled mid-BUSY, result held 20 cycles
      out_ready = 1'b0;
      start_op(tbl[1]);
      repeat (2) begin
         @(posedge clk); #1;
      end
      a = rnd();
      b = rnd();
      wait_out(7);
      for (int i = 0; i < 20; i++) begin
         chk("hold_diff", diff, tbl[1].d);
         chk("hold_ctl", {in_ready, out_valid, eq, gt, lt}, {2'b01, tbl[1].eq, tbl[1].gt, tbl[1].lt});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_release", {in_ready, out_valid}, 2'b10);
      // reset during slice 4 with borrow and nonzero already set
      start_op(tbl[2]);
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("midrst_hs", {in_ready, out_valid}, 2'b10);
      chk("midrst_diff", diff, '0);
      chk("midrst_flags", {eq, gt, lt}, 3'b000);
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      run(tbl[5]);
      for (int i = 0; i < 4000; i++) begin
         logic [W:0] av, bv;
         av = rnd();
         case ($urandom_range(0, 4))
            0: bv = av;
            1: bv = av + 1'b1;
            2: bv = av - 1'b1;
            3: bv = av ^ {1'b1, {W{1'b0}}};
            default: bv = rnd();
         endcase
         e = model(av, bv);
         run(e);
      end
      @(posedge clk); #1;
      chk("scoreboard_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
